t06_border_animator: RTL and testbench

//   Parametrised playfield-border generator for the snake game. Maps score to an arena level,

---
 rtl/t06_border_animator.sv | 165 ++++++++++++++++
 tb/tb_t06_border_animator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/t06_border_animator.sv
// Snake playfield border animator: maps score to an arena level and walks the
// registered border one cell per step tick toward that level's target window.
module t06_border_animator #(
  parameter int unsigned X_W        = 4,
  parameter int unsigned Y_W        = 4,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned GRID_XMAX  = 15,
  parameter int unsigned GRID_YMAX  = 11,
  parameter int unsigned MIN_XMAX   = 8,
  parameter int unsigned MIN_YMAX   = 6,
  parameter int unsigned LEVEL_PTS  = 20,
  parameter int unsigned NUM_LEVELS = 7,
  parameter int unsigned STEP_DIV   = 4,
  parameter int unsigned CENTRED    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_in,
  input  logic               freeze,
  input  logic [SCORE_W-1:0] score,
  input  logic [X_W-1:0]     head_x,
  input  logic [Y_W-1:0]     head_y,
  output logic [X_W-1:0]     XMAX,
  output logic [X_W-1:0]     XMIN,
  output logic [Y_W-1:0]     YMAX,
  output logic [Y_W-1:0]     YMIN,
  output logic               moving,
  output logic               border_step,
  output logic               out_of_bounds,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_MOVE = 2'd2;

  localparam int unsigned    PW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [X_W-1:0] FULL_XMAX  = X_W'(GRID_XMAX);
  localparam logic [Y_W-1:0] FULL_YMAX  = Y_W'(GRID_YMAX);

  logic [1:0]     state_q, state_d;
  logic [X_W-1:0] xmax_q, xmax_d, xmin_q, xmin_d;
  logic [Y_W-1:0] ymax_q, ymax_d, ymin_q, ymin_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           step_q, step_d;
  logic           oob_q, oob_d;

  int unsigned    lvl, ax, ay, sx, sy;
  logic [X_W-1:0] txmin, txmax;
  logic [Y_W-1:0] tymin, tymax;
  logic           at_target;

  // Target window for the current score; recomputed every cycle so retargeting is immediate.
  always_comb begin
    lvl = 32'(score) / LEVEL_PTS;
    if (lvl > NUM_LEVELS) lvl = NUM_LEVELS;
    ax = MIN_XMAX + lvl;
    if (ax > GRID_XMAX) ax = GRID_XMAX;
    ay = MIN_YMAX + lvl;
    if (ay > GRID_YMAX) ay = GRID_YMAX;
    sx = GRID_XMAX - ax;
    sy = GRID_YMAX - ay;
    if (CENTRED != 0) begin
      txmin = X_W'(sx >> 1);
      txmax = X_W'(GRID_XMAX - (sx - (sx >> 1)));
      tymin = Y_W'(sy >> 1);
      tymax = Y_W'(GRID_YMAX - (sy - (sy >> 1)));
    end else begin
      txmin = '0;
      txmax = X_W'(ax);
      tymin = '0;
      tymax = Y_W'(ay);
    end
  end

  always_comb begin
    state_d   = state_q;
    xmax_d    = xmax_q;
    xmin_d    = xmin_q;
    ymax_d    = ymax_q;
    ymin_d    = ymin_q;
    presc_d   = presc_q;
    step_d    = 1'b0;
    at_target = (xmax_q == txmax) && (xmin_q == txmin) &&
                (ymax_q == tymax) && (ymin_q == tymin);
    // Disable beats freeze: the border snaps back to the full grid at once.
    if (!enable_in) begin
      state_d = ST_IDLE;
      xmax_d  = FULL_XMAX;
      xmin_d  = '0;
      ymax_d  = FULL_YMAX;
      ymin_d  = '0;
      presc_d = '0;
    end else if (!freeze) begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (!at_target) begin
            state_d = ST_MOVE;
            presc_d = '0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_MOVE: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            xmax_d = (xmax_q < txmax) ? xmax_q + X_W'(1) :
                     (xmax_q > txmax) ? xmax_q - X_W'(1) : xmax_q;
            xmin_d = (xmin_q < txmin) ? xmin_q + X_W'(1) :
                     (xmin_q > txmin) ? xmin_q - X_W'(1) : xmin_q;
            ymax_d = (ymax_q < tymax) ? ymax_q + Y_W'(1) :
                     (ymax_q > tymax) ? ymax_q - Y_W'(1) : ymax_q;
            ymin_d = (ymin_q < tymin) ? ymin_q + Y_W'(1) :
                     (ymin_q > tymin) ? ymin_q - Y_W'(1) : ymin_q;
            step_d = (xmax_d != xmax_q) || (xmin_d != xmin_q) ||
                     (ymax_d != ymax_q) || (ymin_d != ymin_q);
            if ((xmax_d == txmax) && (xmin_d == txmin) &&
                (ymax_d == tymax) && (ymin_d == tymin)) begin
              state_d = ST_HOLD;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    oob_d = enable_in && (state_q != ST_IDLE) &&
            ((head_x < xmin_q) || (head_x > xmax_q) ||
             (head_y < ymin_q) || (head_y > ymax_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xmax_q  <= FULL_XMAX;
      xmin_q  <= '0;
      ymax_q  <= FULL_YMAX;
      ymin_q  <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xmax_q  <= xmax_d;
      xmin_q  <= xmin_d;
      ymax_q  <= ymax_d;
      ymin_q  <= ymin_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      oob_q   <= oob_d;
    end
  end

  assign XMAX          = xmax_q;
  assign XMIN          = xmin_q;
  assign YMAX          = ymax_q;
  assign YMIN          = ymin_q;
  assign moving        = (state_q == ST_MOVE);
  assign border_step   = step_q;
  assign out_of_bounds = oob_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_t06_border_animator.sv
// Directed bench for t06_border_animator: default, centred and STEP_DIV=1 instances
// share one set of stimulus; expected values are hand-computed per step.
module tb_t06_border_animator;

  logic       clk;
  logic       rst;
  logic       enable_in;
  logic       freeze;
  logic [7:0] score;
  logic [3:0] head_x;
  logic [3:0] head_y;

  logic [3:0] xmax, xmin, ymax, ymin;
  logic       moving, border_step, oob;
  logic [1:0] fsm_state;

  logic [3:0] c_xmax, c_xmin, c_ymax, c_ymin;
  logic       c_moving, c_step, c_oob;
  logic [1:0] c_state;

  logic [3:0] f_xmax, f_xmin, f_ymax, f_ymin;
  logic       f_moving, f_step, f_oob;
  logic [1:0] f_state;

  int n_checks = 0;
  int n_err    = 0;
  int step_cnt = 0;
  int cnt0     = 0;

  t06_border_animator u_dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .freeze(freeze), .score(score),
    .head_x(head_x), .head_y(head_y),
    .XMAX(xmax), .XMIN(xmin), .YMAX(ymax), .YMIN(ymin),
    .moving(moving), .border_step(border_step), .out_of_bounds(oob), .fsm_state(fsm_state)
  );

  t06_border_animator #(.CENTRED(1)) u_ctr (
    .clk(clk), .rst(rst), .enable_in(enable_in), .freeze(freeze), .score(score),
    .head_x(head_x), .head_y(head_y),
    .XMAX(c_xmax), .XMIN(c_xmin), .YMAX(c_ymax), .YMIN(c_ymin),
    .moving(c_moving), .border_step(c_step), .out_of_bounds(c_oob), .fsm_state(c_state)
  );

  t06_border_animator #(.STEP_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .enable_in(enable_in), .freeze(freeze), .score(score),
    .head_x(head_x), .head_y(head_y),
    .XMAX(f_xmax), .XMIN(f_xmin), .YMAX(f_ymax), .YMIN(f_ymin),
    .moving(f_moving), .border_step(f_step), .out_of_bounds(f_oob), .fsm_state(f_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (border_step === 1'b1) step_cnt++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable_in = 1'b0; freeze = 1'b0; score = 8'd0;
    head_x = 4'd0; head_y = 4'd0;
    cyc(2);
    check("rst_xmax", xmax, 15);
    check("rst_xmin", xmin, 0);
    check("rst_ymax", ymax, 11);
    check("rst_ymin", ymin, 0);
    check("rst_moving", moving, 0);
    check("rst_step", border_step, 0);
    check("rst_oob", oob, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    cyc(1);

    // Shrink from full grid to level-0 arena
    enable_in = 1'b1;
    cnt0 = step_cnt;
    cyc(1);
    check("e0_moving", moving, 1);
    check("e0_state", fsm_state, 2);
    check("e0_xmax", xmax, 15);
    cyc(3);
    check("e3_xmax", xmax, 15);
    check("fast_e3_xmax", f_xmax, 12);
    check("fast_e3_ymax", f_ymax, 8);
    cyc(1);
    check("e4_xmax", xmax, 14);
    check("e4_ymax", ymax, 10);
    check("e4_step", border_step, 1);
    cyc(1);
    check("e5_step", border_step, 0);
    cyc(11);
    check("e16_xmax", xmax, 11);
    check("e16_ymax", ymax, 7);
    check("e16_moving", moving, 1);
    check("ctr_xmin", c_xmin, 3);
    check("ctr_xmax", c_xmax, 11);
    check("ctr_ymin", c_ymin, 2);
    check("ctr_ymax", c_ymax, 8);
    check("ctr_moving", c_moving, 0);
    cyc(4);
    check("e20_ymax", ymax, 6);
    check("e20_xmax", xmax, 10);
    cyc(7);
    check("e27_xmax", xmax, 9);
    check("e27_moving", moving, 1);
    cyc(1);
    check("e28_xmax", xmax, 8);
    check("e28_moving", moving, 0);
    check("e28_state", fsm_state, 1);
    cyc(1);
    check("step_pulses", step_cnt - cnt0, 7);
    check("e29_step", border_step, 0);

    // Out-of-bounds flag, one cycle latency
    head_x = 4'd9; head_y = 4'd3;
    cyc(1);
    check("oob_9_3", oob, 1);
    check("ctr_oob_9_3", c_oob, 0);
    head_x = 4'd8; head_y = 4'd6;
    cyc(1);
    check("oob_8_6", oob, 0);
    head_x = 4'd2; head_y = 4'd5;
    cyc(1);
    check("oob_2_5", oob, 0);
    check("ctr_oob_2_5", c_oob, 1);

    // Level 2 grows the arena
    score = 8'd45;
    cyc(1);
    check("f1_moving", moving, 1);
    check("f1_xmax", xmax, 8);
    cyc(4);
    check("f5_xmax", xmax, 9);
    check("f5_ymax", ymax, 7);
    check("ctr_l2_xmin", c_xmin, 2);
    check("ctr_l2_xmax", c_xmax, 12);
    check("ctr_l2_ymin", c_ymin, 1);
    check("ctr_l2_ymax", c_ymax, 9);
    cyc(4);
    check("f9_xmax", xmax, 10);
    check("f9_ymax", ymax, 8);
    check("f9_moving", moving, 0);
    check("ctr_f9_moving", c_moving, 0);

    // Score clamps to top level, with a freeze mid-move
    score = 8'd200;
    cyc(1);
    check("g1_moving", moving, 1);
    cyc(6);
    check("g7_xmax", xmax, 11);
    check("g7_ymax", ymax, 9);
    freeze = 1'b1;
    cyc(10);
    check("frz_xmax", xmax, 11);
    check("frz_ymax", ymax, 9);
    check("frz_moving", moving, 1);
    freeze = 1'b0;
    cyc(1);
    check("g18_xmax", xmax, 11);
    cyc(1);
    check("g19_xmax", xmax, 12);
    check("g19_ymax", ymax, 10);
    check("g19_step", border_step, 1);
    cyc(12);
    check("g31_xmax", xmax, 15);
    check("g31_ymax", ymax, 11);
    check("g31_moving", moving, 0);
    check("ctr_g31_xmin", c_xmin, 0);
    check("ctr_g31_xmax", c_xmax, 15);
    check("ctr_g31_moving", c_moving, 0);

    // Disable during freeze snaps to full grid
    score = 8'd0;
    cyc(1);
    check("h1_moving", moving, 1);
    cyc(4);
    check("h5_xmax", xmax, 14);
    check("h5_ymax", ymax, 10);
    freeze = 1'b1;
    cyc(2);
    check("h7_xmax", xmax, 14);
    enable_in = 1'b0;
    cyc(1);
    check("dis_xmax", xmax, 15);
    check("dis_ymax", ymax, 11);
    check("dis_moving", moving, 0);
    check("dis_state", fsm_state, 0);

    // Asynchronous reset mid-move
    freeze = 1'b0;
    enable_in = 1'b1;
    cyc(1);
    check("j0_moving", moving, 1);
    cyc(12);
    check("j12_xmax", xmax, 12);
    head_x = 4'd15; head_y = 4'd3;
    cyc(1);
    check("j13_oob", oob, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_xmax", xmax, 15);
    check("arst_ymax", ymax, 11);
    check("arst_moving", moving, 0);
    check("arst_oob", oob, 0);
    cyc(1);
    check("rst2_xmax", xmax, 15);
    check("rst2_moving", moving, 0);
    rst = 1'b0;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
